// File: rtl/disp_pkg.sv
// Shared definitions for the hex display controller: register map, CTRL fields,
// segment lookup table and per-digit mask helpers.
package disp_pkg;

    localparam int unsigned MAX_DIGITS      = 16;

    localparam int unsigned ADDR_CTRL       = 0;
    localparam int unsigned ADDR_DECODE_EN  = 1;
    localparam int unsigned ADDR_BLINK_MASK = 2;
    localparam int unsigned ADDR_BLINK_DIV  = 3;
    localparam int unsigned ADDR_VALUE_LO   = 4;
    localparam int unsigned ADDR_VALUE_HI   = 5;
    localparam int unsigned ADDR_RAW0       = 8;
    localparam int unsigned ADDR_RAW3       = 11;

    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_LZ_BIT     = 1;
    localparam int unsigned CTRL_BRIGHT_LSB = 8;
    localparam logic [4:0]  BRIGHT_MAX      = 5'd16;

    // Segment order gfedcba, active-high.
    function automatic logic [6:0] seg_table(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++)
            m[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        return m;
    endfunction

    function automatic logic [4:0] bright_clamp(input logic [4:0] b);
        return (b > BRIGHT_MAX) ? BRIGHT_MAX : b;
    endfunction

    function automatic logic [15:0] digit_mask(input int n);
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = (i < n);
        return m;
    endfunction

    function automatic logic [63:0] nibble_mask(input int n);
        logic [63:0] m;
        for (int i = 0; i < 16; i++) m[4*i +: 4] = (i < n) ? 4'hF : 4'h0;
        return m;
    endfunction

    // Raw bytes keep only bits 6:0; bit 7 always reads back 0.
    function automatic logic [127:0] raw_mask(input int n);
        logic [127:0] m;
        for (int i = 0; i < 16; i++) m[8*i +: 8] = (i < n) ? 8'h7F : 8'h00;
        return m;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_seg_decode.sv
// Hex nibble to gfedcba segment pattern (active-high).
// Latency: combinational. Backpressure: none.
// Flow: pure lookup, no handshake.
module seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = seg_table(nibble);
endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM seven-segment controller: decode/raw per digit, LZ suppression, blink, PWM (DISP_PWM_EN).
// Latency: readdata 1 cycle after read; register writes reach seg_n 2 cycles after the write.
// Backpressure: none, the slave accepts every read and write in a single cycle.
module hex_display_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int BLINK_DIV_W = 32,
    parameter int ADDR_W      = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic [3:0]              byteenable,
    input  logic                    read,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] seg_n
);

    localparam logic [15:0]  DIG_MASK = digit_mask(NUM_DIGITS);
    localparam logic [63:0]  NIB_MASK = nibble_mask(NUM_DIGITS);
    localparam logic [127:0] RAW_MASK = raw_mask(NUM_DIGITS);

    logic [31:0]            addr;
    logic [31:0]            rd_word;
    logic [31:0]            merged;
    logic                   ctrl_en_q, ctrl_lz_q;
    logic [4:0]             bright;
    logic [15:0]            decode_q, blink_mask_q;
    logic [BLINK_DIV_W-1:0] blink_div_q, blink_cnt_q;
    logic                   phase_q;
    logic [63:0]            value_q;
    logic [127:0]           raw_q;
    logic                   lit_pwm;
    logic [15:0]            suppressed;
    logic                   blanking;
    logic [7*NUM_DIGITS-1:0] seg_d;

    assign addr   = 32'(address);
    assign merged = byte_merge(rd_word, writedata, byteenable);

    always_comb begin
        rd_word = '0;
        case (addr)
            ADDR_CTRL: begin
                rd_word[CTRL_ENABLE_BIT]      = ctrl_en_q;
                rd_word[CTRL_LZ_BIT]          = ctrl_lz_q;
                rd_word[CTRL_BRIGHT_LSB +: 5] = bright;
            end
            ADDR_DECODE_EN:  rd_word[15:0] = decode_q;
            ADDR_BLINK_MASK: rd_word[15:0] = blink_mask_q;
            ADDR_BLINK_DIV:  rd_word       = 32'(blink_div_q);
            ADDR_VALUE_LO:   rd_word       = value_q[31:0];
            ADDR_VALUE_HI:   rd_word       = value_q[63:32];
            default: begin
                if (addr >= ADDR_RAW0 && addr <= ADDR_RAW3)
                    rd_word = raw_q[{addr[1:0], 5'd0} +: 32];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en_q    <= 1'b0;
            ctrl_lz_q    <= 1'b0;
            decode_q     <= DIG_MASK;
            blink_mask_q <= '0;
            blink_div_q  <= '0;
            value_q      <= '0;
            raw_q        <= '0;
        end else if (write) begin
            case (addr)
                ADDR_CTRL: begin
                    ctrl_en_q <= merged[CTRL_ENABLE_BIT];
                    ctrl_lz_q <= merged[CTRL_LZ_BIT];
                end
                ADDR_DECODE_EN:  decode_q       <= merged[15:0] & DIG_MASK;
                ADDR_BLINK_MASK: blink_mask_q   <= merged[15:0] & DIG_MASK;
                ADDR_BLINK_DIV:  blink_div_q    <= BLINK_DIV_W'(merged);
                ADDR_VALUE_LO:   value_q[31:0]  <= merged & NIB_MASK[31:0];
                ADDR_VALUE_HI:   value_q[63:32] <= merged & NIB_MASK[63:32];
                default: begin
                    if (addr >= ADDR_RAW0 && addr <= ADDR_RAW3)
                        raw_q[{addr[1:0], 5'd0} +: 32] <=
                            merged & RAW_MASK[{addr[1:0], 5'd0} +: 32];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= read ? rd_word : 32'd0;
    end

    // Any write to BLINK_DIV restarts the half-period so the new rate begins lit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if ((write && addr == ADDR_BLINK_DIV) || blink_div_q == '0) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (blink_cnt_q >= blink_div_q - BLINK_DIV_W'(1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_DIV_W'(1);
        end
    end

`ifdef DISP_PWM_EN
    logic [3:0] pwm_cnt_q;
    logic [4:0] bright_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= 4'd0;
            bright_q  <= BRIGHT_MAX;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
            if (write && addr == ADDR_CTRL)
                bright_q <= bright_clamp(merged[CTRL_BRIGHT_LSB +: 5]);
        end
    end

    assign bright  = bright_q;
    assign lit_pwm = {1'b0, pwm_cnt_q} < bright_q;
`else
    assign bright  = BRIGHT_MAX;
    assign lit_pwm = 1'b1;
`endif

    // Blank decoded zeros from the top digit down until a nonzero or raw digit.
    always_comb begin
        suppressed = '0;
        blanking   = ctrl_lz_q;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < NUM_DIGITS) begin
                if (blanking && decode_q[i] && value_q[4*i +: 4] == 4'd0)
                    suppressed[i] = 1'b1;
                else
                    blanking = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [6:0] dec_pat, pattern;
        logic       digit_on;

        seg_decode u_seg_decode (
            .nibble (value_q[4*g +: 4]),
            .seg    (dec_pat)
        );

        assign pattern  = decode_q[g] ? dec_pat : raw_q[8*g +: 7];
        assign digit_on = ctrl_en_q & ~suppressed[g] & (~blink_mask_q[g] | phase_q) & lit_pwm;
        assign seg_d[7*g +: 7] = digit_on ? ~pattern : 7'h7F;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) seg_n <= '1;
        else          seg_n <= seg_d;
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed register/display scenarios followed by random
// register traffic checked against a time-based behavioural model of the display.
`timescale 1ns/1ps
module tb_hex_display_ctrl;

    localparam int N  = 8;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   address;
    logic            write;
    logic [31:0]     writedata;
    logic [3:0]      byteenable;
    logic            read;
    logic [31:0]     readdata;
    logic [7*N-1:0]  seg_n;

    always #5 clk = ~clk;

    hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV_W(32), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .byteenable (byteenable),
        .read       (read),
        .readdata   (readdata),
        .seg_n      (seg_n)
    );

    int total = 0;
    int bad   = 0;
    int edge_no = 0;

    // Model state: register contents plus the edge at which BLINK_DIV was last written.
    bit          m_en, m_lz;
    int          m_bright;
    bit          m_dec[16];
    bit          m_blink[16];
    logic [31:0] m_div;
    int          m_wdiv;
    logic [3:0]  m_nib[16];
    logic [6:0]  m_raw[16];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic void reset_model();
        m_en = 0; m_lz = 0; m_bright = 16; m_div = 0; m_wdiv = 0;
        for (int i = 0; i < 16; i++) begin
            m_dec[i] = (i < N); m_blink[i] = 0; m_nib[i] = 0; m_raw[i] = 0;
        end
    endfunction

    function automatic void model_write(input int a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                case (a)
                    0: begin
                        if (b == 0) begin
                            m_en = d[0]; m_lz = d[1];
                        end
`ifdef DISP_PWM_EN
                        if (b == 1) m_bright = (d[12:8] > 5'd16) ? 16 : int'(d[12:8]);
`endif
                    end
                    1, 2: for (int k = 0; k < 8; k++) begin
                        if (8*b + k < N) begin
                            if (a == 1) m_dec[8*b + k]   = d[8*b + k];
                            else        m_blink[8*b + k] = d[8*b + k];
                        end
                    end
                    3: m_div[8*b +: 8] = d[8*b +: 8];
                    4, 5: for (int k = 0; k < 2; k++) begin
                        int dg;
                        dg = (a - 4) * 8 + 2*b + k;
                        if (dg < N) m_nib[dg] = d[8*b + 4*k +: 4];
                    end
                    8, 9, 10, 11: begin
                        int dg;
                        dg = (a - 8) * 4 + b;
                        if (dg < N) m_raw[dg] = d[8*b +: 7];
                    end
                    default: ;
                endcase
            end
        end
        if (a == 3) m_wdiv = edge_no;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] r;
        r = '0;
        case (a)
            0: begin r[0] = m_en; r[1] = m_lz; r[12:8] = 5'(m_bright); end
            1: for (int k = 0; k < 16; k++) r[k] = m_dec[k];
            2: for (int k = 0; k < 16; k++) r[k] = m_blink[k];
            3: r = m_div;
            4: for (int k = 0; k < 8; k++) r[4*k +: 4] = m_nib[k];
            5: for (int k = 0; k < 8; k++) r[4*k +: 4] = m_nib[8 + k];
            8, 9, 10, 11: for (int j = 0; j < 4; j++) r[8*j +: 7] = m_raw[(a - 8)*4 + j];
            default: r = '0;
        endcase
        return r;
    endfunction

    // seg_n seen now reflects registers and counters as they stood one edge earlier.
    function automatic logic [7*N-1:0] model_seg();
        logic [7*N-1:0] s;
        logic [6:0]     pat;
        bit             phase, lit, sup, lit_d;
        int             k;
        k = edge_no - 1;
        s = '0;
        if (m_div == 0) phase = 1'b1;
        else            phase = (((k - m_wdiv) / int'(m_div)) % 2) == 0;
`ifdef DISP_PWM_EN
        lit = (k % 16) < m_bright;
`else
        lit = 1'b1;
`endif
        for (int i = 0; i < N; i++) begin
            sup = m_lz && (i > 0);
            for (int j = i; j < N; j++)
                if (!(m_dec[j] && m_nib[j] == 4'd0)) sup = 1'b0;
            pat   = m_dec[i] ? seg_ref(m_nib[i]) : m_raw[i];
            lit_d = m_en && !sup && (!m_blink[i] || phase) && lit;
            s[7*i +: 7] = lit_d ? ~pat : 7'h7F;
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        address = AW'(a); writedata = d; byteenable = be; write = 1'b1;
        tick();
        write = 1'b0;
        model_write(a, d, be);
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        address = AW'(a); read = 1'b1;
        tick();
        read = 1'b0;
        d = readdata;
    endtask

    logic [31:0]    rdat;
    logic [7*N-1:0] all_dark;
    int             lit_cnt;
    int             exp_lit;
    int             alist[12] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 6, 15};

    initial begin
        all_dark = '1;
        reset_n = 1'b0; address = '0; write = 1'b0; writedata = '0;
        byteenable = '0; read = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_seg", seg_n, all_dark);
        chk("reset_rdata", readdata, 32'd0);
        reset_n = 1'b1;
        edge_no = 0;

        rd(0, rdat);
        chk("reset_ctrl", rdat, 32'h0000_1000);
        rd(1, rdat);
        chk("reset_decode_en", rdat, 32'h0000_00FF);
        tick();
        chk("rdata_idle", readdata, 32'd0);

        // Decode display and 2-cycle write-to-segment latency
        wr(0, 32'h0000_1001, 4'hF);
        wr(4, 32'h0000_00A0, 4'hF);
        chk("lat_not_yet", seg_n[13:7], 7'h40);
        tick();
        chk("dec_d0", seg_n[6:0], 7'h40);
        chk("dec_d1", seg_n[13:7], 7'h08);
        chk("dec_all", seg_n, {{6{7'h40}}, 7'h08, 7'h40});

        // Leading-zero suppression
        wr(0, 32'h0000_1003, 4'hF);
        tick();
        chk("lz_a0", seg_n, {{6{7'h7F}}, 7'h08, 7'h40});
        wr(4, 32'h0, 4'hF);
        tick();
        chk("lz_zero", seg_n, {{7{7'h7F}}, 7'h40});

        // Raw digit with single byte lane, bit7 dropped
        wr(0, 32'h0000_1001, 4'hF);
        wr(1, 32'h0000_00FE, 4'hF);
        wr(8, 32'h5555_55C9, 4'b0001);
        tick();
        chk("raw_d0", seg_n, {{7{7'h40}}, 7'h36});
        rd(8, rdat);
        chk("raw_rd", rdat, 32'h0000_0049);

        // Blink
        wr(1, 32'h0000_00FF, 4'hF);
        wr(2, 32'h0000_0001, 4'hF);
        wr(3, 32'd4, 4'hF);
        for (int t = 0; t < 16; t++) begin
            tick();
            chk("blink_d0", seg_n[6:0], ((t / 4) % 2 == 0) ? 7'h40 : 7'h7F);
            chk("blink_d1", seg_n[13:7], 7'h40);
        end
        wr(3, 32'd0, 4'hF);
        for (int t = 0; t < 8; t++) begin
            tick();
            chk("blink_off_d0", seg_n[6:0], 7'h40);
        end

        // Brightness
`ifdef DISP_PWM_EN
        exp_lit = 4;
`else
        exp_lit = 16;
`endif
        wr(0, 32'h0000_0401, 4'hF);
        tick();
        lit_cnt = 0;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (seg_n[6:0] != 7'h7F) lit_cnt++;
        end
        chk("pwm_b4", 32'(lit_cnt), 32'(exp_lit));
`ifdef DISP_PWM_EN
        exp_lit = 0;
`endif
        wr(0, 32'h0000_0001, 4'hF);
        tick();
        lit_cnt = 0;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (seg_n[6:0] != 7'h7F) lit_cnt++;
        end
        chk("pwm_b0", 32'(lit_cnt), 32'(exp_lit));
        wr(0, 32'h0000_1F01, 4'hF);
        rd(0, rdat);
        chk("bright_clamp", rdat, 32'h0000_1001);

        // Unmapped / out-of-range digits / byte lanes
        wr(6, 32'hDEAD_BEEF, 4'hF);
        rd(6, rdat);
        chk("unmapped", rdat, 32'd0);
        wr(5, 32'h1234_5678, 4'hF);
        rd(5, rdat);
        chk("value_hi", rdat, 32'd0);
        wr(1, 32'hFFFF_FFFF, 4'hF);
        rd(1, rdat);
        chk("decode_mask", rdat, 32'h0000_00FF);
        wr(4, 32'h8765_4321, 4'b0100);
        rd(4, rdat);
        chk("byte_lane", rdat, 32'h0065_0000);

        // Read and write to the same word in one cycle returns the old value
        address = AW'(4); writedata = 32'h1111_1111; byteenable = 4'hF;
        write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        model_write(4, 32'h1111_1111, 4'hF);
        chk("rw_old", readdata, 32'h0065_0000);
        rd(4, rdat);
        chk("rw_new", rdat, 32'h1111_1111);

        // Asynchronous reset mid-operation
        address = AW'(0); read = 1'b1;
        tick();
        read = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("areset_seg", seg_n, all_dark);
        chk("areset_rdata", readdata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        edge_no = 0;
        reset_model();
        rd(0, rdat);
        chk("areset_ctrl", rdat, 32'h0000_1000);
        rd(4, rdat);
        chk("areset_value", rdat, 32'd0);

        // Random register traffic against the model
        for (int it = 0; it < 80; it++) begin
            int          a, n, ra;
            logic [31:0] d;
            logic [3:0]  be;
            a  = alist[$urandom_range(0, 11)];
            d  = $urandom;
            be = 4'($urandom_range(1, 15));
            if (a == 3) d = 32'($urandom_range(0, 6));
            if (a == 0) d[0] = ($urandom_range(0, 3) != 0);
            wr(a, d, be);
            n = $urandom_range(1, 5);
            for (int c = 0; c < n; c++) begin
                tick();
                chk("rand_seg", seg_n, model_seg());
            end
            if ($urandom_range(0, 1) == 1) begin
                ra = alist[$urandom_range(0, 11)];
                rd(ra, rdat);
                chk("rand_rd", rdat, model_read(ra));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
